sram_arbiter: RTL

Two-port arbiter sharing one `sram_23lc1024` instance between two independent requesters, e.g. a `fifo_extmem` and a UART dump/debug reader. Each port issues single-cycle read/write request pulses and receives a single-cycle completion pulse, matching the sram controller's own handshake. The block latches requests, grants round-robin, and sequences exactly one memory transaction at a time. A watchdog guarantees every accepted request eventually completes.

---
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin front end that lets two requesters share one
// sram controller. Each port latches a single outstanding request. The arbiter
// issues one memory transaction at a time and routes the completion back to
// the port that owns it. A watchdog frees a port whose transaction never completes.
module sram_arbiter #(
  parameter int ADDR_BITS = 17,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_wr_en,
  input  logic                 a_rd_en,
  input  logic [ADDR_BITS-1:0] a_address,
  input  logic [DATA_BITS-1:0] a_wr_data,
  output logic [DATA_BITS-1:0] a_rd_data,
  output logic                 a_completed,
  output logic                 a_pending,
  input  logic                 b_wr_en,
  input  logic                 b_rd_en,
  input  logic [ADDR_BITS-1:0] b_address,
  input  logic [DATA_BITS-1:0] b_wr_data,
  output logic [DATA_BITS-1:0] b_rd_data,
  output logic                 b_completed,
  output logic                 b_pending,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0] mem_data_out,
  input  logic [DATA_BITS-1:0] mem_data_in,
  input  logic                 mem_completed,
  output logic                 error,
  output logic                 last_grant
);

  // Watchdog counter is sized to hold TIMEOUT itself; TIMEOUT of 0 disables it.
  localparam int WD_BITS = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  // Per-port request latches, index 0 = port A, index 1 = port B.
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           op_wr_q, op_wr_d;
  logic [1:0]           done_q, done_d;
  logic [ADDR_BITS-1:0] addr_q [2];
  logic [ADDR_BITS-1:0] addr_d [2];
  logic [DATA_BITS-1:0] wdat_q [2];
  logic [DATA_BITS-1:0] wdat_d [2];
  logic [DATA_BITS-1:0] rd_data_q [2];
  logic [DATA_BITS-1:0] rd_data_d [2];

  // Port currently owning the memory, and the round-robin pointer.
  logic                 sel_q, sel_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant;

  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_BITS-1:0] mem_address_q, mem_address_d;
  logic [DATA_BITS-1:0] mem_data_out_q, mem_data_out_d;
  logic                 error_q, error_d;
  logic [WD_BITS-1:0]   wd_q, wd_d;

  logic [1:0]           req_wr, req_rd;
  logic [ADDR_BITS-1:0] req_addr [2];
  logic [DATA_BITS-1:0] req_data [2];

  assign req_wr      = {b_wr_en, a_wr_en};
  assign req_rd      = {b_rd_en, a_rd_en};
  assign req_addr[0] = a_address;
  assign req_addr[1] = b_address;
  assign req_data[0] = a_wr_data;
  assign req_data[1] = b_wr_data;

  assign a_rd_data    = rd_data_q[0];
  assign a_completed  = done_q[0];
  assign a_pending    = pend_q[0];
  assign b_rd_data    = rd_data_q[1];
  assign b_completed  = done_q[1];
  assign b_pending    = pend_q[1];
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign error        = error_q;
  assign last_grant   = last_grant_q;

  // Next-state logic: grant/issue in IDLE, completion or watchdog in WAIT, then request capture.
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    op_wr_d        = op_wr_q;
    done_d         = '0;
    addr_d         = addr_q;
    wdat_d         = wdat_q;
    rd_data_d      = rd_data_q;
    sel_d          = sel_q;
    last_grant_d   = last_grant_q;
    grant          = 1'b0;
    mem_wr_en_d    = 1'b0;
    mem_rd_en_d    = 1'b0;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    error_d        = 1'b0;
    wd_d           = wd_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          // Under contention the port not served last wins; otherwise the lone requester.
          grant          = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          sel_d          = grant;
          last_grant_d   = grant;
          mem_wr_en_d    = op_wr_q[grant];
          mem_rd_en_d    = ~op_wr_q[grant];
          mem_address_d  = addr_q[grant];
          mem_data_out_d = wdat_q[grant];
          wd_d           = '0;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_completed) begin
          // A real completion takes priority over a watchdog expiry in the same cycle.
          if (!op_wr_q[sel_q]) begin
            rd_data_d[sel_q] = mem_data_in;
          end
          done_d[sel_q] = 1'b1;
          pend_d[sel_q] = 1'b0;
          state_d       = S_IDLE;
        end else if (TIMEOUT != 0 && wd_q == WD_LIMIT) begin
          done_d[sel_q] = 1'b1;
          pend_d[sel_q] = 1'b0;
          error_d       = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_d = wd_q + WD_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A port only takes a new request while empty; a write beats a simultaneous read.
    for (int p = 0; p < 2; p++) begin
      if (!pend_q[p] && (req_wr[p] || req_rd[p])) begin
        pend_d[p]  = 1'b1;
        op_wr_d[p] = req_wr[p];
        addr_d[p]  = req_addr[p];
        wdat_d[p]  = req_data[p];
      end
    end
  end

  // State register; reset abandons any transaction in flight and favours A next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      op_wr_q        <= '0;
      done_q         <= '0;
      sel_q          <= 1'b0;
      last_grant_q   <= 1'b1;
      mem_wr_en_q    <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      error_q        <= 1'b0;
      wd_q           <= '0;
      for (int p = 0; p < 2; p++) begin
        addr_q[p]    <= '0;
        wdat_q[p]    <= '0;
        rd_data_q[p] <= '0;
      end
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      op_wr_q        <= op_wr_d;
      done_q         <= done_d;
      sel_q          <= sel_d;
      last_grant_q   <= last_grant_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      error_q        <= error_d;
      wd_q           <= wd_d;
      for (int p = 0; p < 2; p++) begin
        addr_q[p]    <= addr_d[p];
        wdat_q[p]    <= wdat_d[p];
        rd_data_q[p] <= rd_data_d[p];
      end
    end
  end

endmodule
